matrix_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port matrix memory bank between the host loader (UART side) and the matrix multiplier core. It sits between the two requesters and one matrix_memory instance, driving that instance's addr/data_in/write_en/read_en and routing its registered data_out back to whichever requester issued the read. Arbitration is sticky round-robin with a burst limit, so neither side starves while the other streams.

---
 rtl/matrix_mem_arbiter_if.sv | 27 ++
 rtl/matrix_mem_arbiter.sv | 116 +++++++++++
 tb/tb_matrix_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mem_arbiter_if.sv
// Bus bundle between the two requesters (host loader, multiplier core),
// the arbiter, and the single-port matrix memory bank.
interface matrix_mem_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  h_req, h_we, h_gnt, h_rvalid;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0] h_wdata, h_rdata;
    logic                  c_req, c_we, c_gnt, c_rvalid;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata, c_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in, mem_data_out;
    logic                  mem_write_en, mem_read_en;

    modport slave (
        input  h_req, h_we, h_addr, h_wdata, c_req, c_we, c_addr, c_wdata, mem_data_out,
        output h_gnt, h_rvalid, h_rdata, c_gnt, c_rvalid, c_rdata,
        output mem_addr, mem_data_in, mem_write_en, mem_read_en
    );
    modport master (
        output h_req, h_we, h_addr, h_wdata, c_req, c_we, c_addr, c_wdata, mem_data_out,
        input  h_gnt, h_rvalid, h_rdata, c_gnt, c_rvalid, c_rdata,
        input  mem_addr, mem_data_in, mem_write_en, mem_read_en
    );
endinterface

// File: rtl/matrix_mem_arbiter.sv
// Sticky round-robin arbiter with a burst limit sharing one matrix memory bank
// between the host loader and the multiplier core; routes read data back.
module matrix_mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_mem_arbiter_if.slave  bus,
    output logic [1:0]           owner,
    output logic [15:0]          conflict_count
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_HOST = 2'b01,
        OWN_CORE = 2'b10
    } owner_t;

    owner_t                state_q, state_d;
    logic [CW-1:0]         run_q, run_d;
    logic                  h_gnt, c_gnt, h_rv_q, c_rv_q;
    logic                  we_sel;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OWN_NONE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Grants are purely combinational so a request is accepted the cycle it is seen.
    always_comb begin
        h_gnt   = 1'b0;
        c_gnt   = 1'b0;
        state_d = OWN_NONE;
        run_d   = '0;
        if (rst_n) begin
            if (bus.h_req && bus.c_req) begin
                case (state_q)
                    OWN_HOST: c_gnt = (run_q == BURST);
                    OWN_CORE: c_gnt = (run_q != BURST);
                    default:  c_gnt = 1'b1;
                endcase
                h_gnt = !c_gnt;
            end else begin
                h_gnt = bus.h_req;
                c_gnt = bus.c_req;
            end
            if (h_gnt) begin
                state_d = OWN_HOST;
                run_d   = (state_q != OWN_HOST) ? CW'(1) :
                          (run_q == BURST)      ? BURST : run_q + 1'b1;
            end else if (c_gnt) begin
                state_d = OWN_CORE;
                run_d   = (state_q != OWN_CORE) ? CW'(1) :
                          (run_q == BURST)      ? BURST : run_q + 1'b1;
            end
        end
    end

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (h_gnt) begin
            we_sel    = bus.h_we;
            addr_sel  = bus.h_addr;
            wdata_sel = bus.h_wdata;
        end else if (c_gnt) begin
            we_sel    = bus.c_we;
            addr_sel  = bus.c_addr;
            wdata_sel = bus.c_wdata;
        end
    end

    assign bus.mem_addr     = addr_sel;
    assign bus.mem_data_in  = wdata_sel;
    assign bus.mem_write_en = (h_gnt || c_gnt) && we_sel;
    assign bus.mem_read_en  = (h_gnt || c_gnt) && !we_sel;
    assign bus.h_gnt        = h_gnt;
    assign bus.c_gnt        = c_gnt;

    // Memory output is registered, so the read tag only needs one stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_rv_q <= 1'b0;
            c_rv_q <= 1'b0;
        end else begin
            h_rv_q <= h_gnt && !bus.h_we;
            c_rv_q <= c_gnt && !bus.c_we;
        end
    end

    assign bus.h_rvalid = h_rv_q;
    assign bus.c_rvalid = c_rv_q;
    assign bus.h_rdata  = h_rv_q ? bus.mem_data_out : '0;
    assign bus.c_rdata  = c_rv_q ? bus.mem_data_out : '0;

    always_ff @(posedge clk) begin
        if (!rst_n)
            conflict_count <= '0;
        else if (bus.h_req && bus.c_req && conflict_count != 16'hFFFF)
            conflict_count <= conflict_count + 16'd1;
    end

    assign owner = state_q;
endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Bench for matrix_mem_arbiter: directed stimulus, read responses scoreboarded
// through a queue and checked by an independent monitor.
module tb_matrix_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  owner;
    logic [15:0] conflict_count;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        bit          core;
        logic [15:0] data;
        int          cyc;
    } rsp_t;
    rsp_t exp_q[$];

    matrix_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matrix_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .owner          (owner),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port bank with registered read data
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        bus.mem_data_out = '0;
    end
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_data_in;
        if (bus.mem_read_en)  bus.mem_data_out <= mem[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                         input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        bus.h_req = hr; bus.h_we = hw; bus.h_addr = ha; bus.h_wdata = hd;
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input bit core, input logic [15:0] data);
        rsp_t e;
        e.core = core;
        e.data = data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: compares each presented read response with the scoreboard head
    always @(negedge clk) begin
        if (bus.h_rvalid && bus.c_rvalid) chk("single_rvalid", 32'(bus.c_rvalid), 32'(0));
        if (!bus.h_rvalid) chk("h_rdata_idle", 32'(bus.h_rdata), 32'(0));
        if (!bus.c_rvalid) chk("c_rdata_idle", 32'(bus.c_rdata), 32'(0));
        if (bus.h_rvalid || bus.c_rvalid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rvalid: h_rvalid=%0b c_rvalid=%0b with nothing expected (cycle %0d)",
                         bus.h_rvalid, bus.c_rvalid, cyc);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_requester", 32'(bus.c_rvalid), 32'(e.core));
                chk("rsp_data", 32'(e.core ? bus.c_rdata : bus.h_rdata), 32'(e.data));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);

        // Reset with both requesting
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rst_n = 1'b0;
            drive(1, 0, 10'h001, '0, 1, 0, 10'h002, '0);
            @(negedge clk);
            chk("rst_h_gnt", 32'(bus.h_gnt), 0);
            chk("rst_c_gnt", 32'(bus.c_gnt), 0);
            chk("rst_we", 32'(bus.mem_write_en), 0);
            chk("rst_re", 32'(bus.mem_read_en), 0);
            if (i > 0) begin
                chk("rst_owner", 32'(owner), 0);
                chk("rst_conflict", 32'(conflict_count), 0);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("post_rst_owner", 32'(owner), 0);
        chk("post_rst_conflict", 32'(conflict_count), 0);

        // Host write 0x1234 @0x005, then core read
        next_cycle();
        drive(1, 1, 10'h005, 16'h1234, 0, 0, '0, '0);
        @(negedge clk);
        chk("hw_gnt", 32'(bus.h_gnt), 1);
        chk("hw_c_gnt", 32'(bus.c_gnt), 0);
        chk("hw_we", 32'(bus.mem_write_en), 1);
        chk("hw_addr", 32'(bus.mem_addr), 32'h005);
        chk("hw_data", 32'(bus.mem_data_in), 32'h1234);
        next_cycle();
        drive(0, 0, '0, '0, 1, 0, 10'h005, '0);
        push_rsp(1, 16'h1234);
        @(negedge clk);
        chk("cr_gnt", 32'(bus.c_gnt), 1);
        chk("cr_re", 32'(bus.mem_read_en), 1);
        chk("cr_we", 32'(bus.mem_write_en), 0);
        chk("cr_addr", 32'(bus.mem_addr), 32'h005);
        chk("cr_owner_prev", 32'(owner), 1);
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("cr_owner", 32'(owner), 2);
        chk("idle_re", 32'(bus.mem_read_en), 0);
        chk("idle_addr", 32'(bus.mem_addr), 0);

        // Contention from idle: core 0-3, host 4-7, core 8-11
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            drive(1, 1, 10'(10'h100 + i), 16'(16'hA000 + i), 1, 1, 10'(10'h200 + i), 16'(16'hB000 + i));
            @(negedge clk);
            chk("cont_c_gnt", 32'(bus.c_gnt), 32'(((i / 4) % 2) == 0));
            chk("cont_h_gnt", 32'(bus.h_gnt), 32'(((i / 4) % 2) == 1));
            chk("cont_addr", 32'(bus.mem_addr), 32'((((i / 4) % 2) == 0) ? 32'h200 + i : 32'h100 + i));
            chk("cont_conflict", 32'(conflict_count), 32'(i));
        end
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("cont_conflict_12", 32'(conflict_count), 12);
        chk("cont_owner", 32'(owner), 2);

        // Owner drop: host run of 2, then core alone, then both
        next_cycle();
        drive(1, 1, 10'h010, 16'h0001, 0, 0, '0, '0);
        @(negedge clk);
        chk("drop_owner_idle", 32'(owner), 0);
        chk("drop_h1", 32'(bus.h_gnt), 1);
        next_cycle();
        drive(1, 1, 10'h011, 16'h0002, 0, 0, '0, '0);
        @(negedge clk);
        chk("drop_h2", 32'(bus.h_gnt), 1);
        chk("drop_owner_h", 32'(owner), 1);
        next_cycle();
        drive(0, 0, '0, '0, 1, 1, 10'h020, 16'h0003);
        @(negedge clk);
        chk("drop_c_gnt", 32'(bus.c_gnt), 1);
        chk("drop_h_gnt", 32'(bus.h_gnt), 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1, 1, 10'h012, 16'h0004, 1, 1, 10'(10'h021 + i), 16'h0005);
            @(negedge clk);
            if (i == 0) chk("drop_owner_c", 32'(owner), 2);
            chk("drop_burst_c", 32'(bus.c_gnt), 32'(i < 3));
            chk("drop_burst_h", 32'(bus.h_gnt), 32'(i == 3));
        end
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);

        // Pipelined host read / write / read at 0x3FF
        next_cycle();
        drive(1, 0, 10'h3FF, '0, 0, 0, '0, '0);
        push_rsp(0, 16'h0000);
        @(negedge clk);
        chk("pipe_rd1_re", 32'(bus.mem_read_en), 1);
        next_cycle();
        drive(1, 1, 10'h3FF, 16'hBEEF, 0, 0, '0, '0);
        @(negedge clk);
        chk("pipe_wr_we", 32'(bus.mem_write_en), 1);
        chk("pipe_wr_gnt", 32'(bus.h_gnt), 1);
        next_cycle();
        drive(1, 0, 10'h3FF, '0, 0, 0, '0, '0);
        push_rsp(0, 16'hBEEF);
        @(negedge clk);
        chk("pipe_rd2_re", 32'(bus.mem_read_en), 1);
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        next_cycle();

        // Reset mid-operation: read accepted just before reset still returns
        drive(1, 0, 10'h005, '0, 0, 0, '0, '0);
        push_rsp(0, 16'h1234);
        @(negedge clk);
        chk("mid_rd_gnt", 32'(bus.h_gnt), 1);
        next_cycle();
        rst_n = 1'b0;
        drive(1, 0, 10'h005, '0, 1, 0, 10'h006, '0);
        @(negedge clk);
        chk("mid_rst_h_gnt", 32'(bus.h_gnt), 0);
        chk("mid_rst_c_gnt", 32'(bus.c_gnt), 0);
        chk("mid_rst_re", 32'(bus.mem_read_en), 0);
        next_cycle();
        @(negedge clk);
        chk("mid_rst_owner", 32'(owner), 0);
        chk("mid_rst_conflict", 32'(conflict_count), 0);
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);

        // Saturation: both requesting well past 0xFFFF cycles
        for (int i = 0; i < 65540; i++) begin
            next_cycle();
            drive(1, 1, 10'h030, 16'h1111, 1, 1, 10'h031, 16'h2222);
            @(negedge clk);
            chk("sat_c_gnt", 32'(bus.c_gnt), 32'(((i / MB) % 2) == 0));
            chk("sat_conflict", 32'(conflict_count), 32'((i > 65535) ? 65535 : i));
        end
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        chk("sat_final", 32'(conflict_count), 32'hFFFF);
        next_cycle();
        next_cycle();
        chk("rsp_queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
